// File: rtl/shared_stage_arb_if.sv
// Handshake bundle between two requesters, the shared stage and its sink.
// master: arbiter side (drives grants and y_*); slave: producers/sink side.
interface shared_stage_arb_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 16
);
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt1;
    logic             req2;
    logic [WIDTH-1:0] data2;
    logic             gnt2;
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             y_owner;
    logic [CW-1:0]    xfer_cnt;

    modport master (
        input  req1, data1, req2, data2, y_ready,
        output gnt1, gnt2, y_data, y_valid, y_owner, xfer_cnt
    );

    modport slave (
        output req1, data1, req2, data2, y_ready,
        input  gnt1, gnt2, y_data, y_valid, y_owner, xfer_cnt
    );
endinterface

// File: rtl/shared_stage_arb.sv
// Round-robin, burst-bounded arbiter sharing one output register between
// two requesters. Ports: clk, rst (sync, active-high), bus (master modport).
module shared_stage_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    shared_stage_arb_if.master  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_owner;
    logic [CW-1:0]    r_cnt;
    logic             r_last;
    logic [7:0]       r_burst;

    logic w_free;
    logic w_sel;
    logic w_gnt1;
    logic w_gnt2;
    logic w_gnt;

    // Slot can take a new word when empty or when its word leaves now.
    assign w_free = (r_state == EMPTY) || bus.y_ready;

    // Holder keeps priority until its burst is exhausted.
    always_comb begin
        w_sel = 1'b0;
        if (bus.req1 && bus.req2)
            w_sel = (r_burst < LP_MAX) ? r_last : !r_last;
        else if (bus.req2)
            w_sel = 1'b1;
    end

    assign w_gnt1 = bus.req1 && w_free && !w_sel;
    assign w_gnt2 = bus.req2 && w_free && w_sel;
    assign w_gnt  = w_gnt1 || w_gnt2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_owner <= 1'b0;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_burst <= LP_MAX;
        end else begin
            unique case (r_state)
                EMPTY: if (w_gnt) r_state <= FULL;
                FULL:  if (!w_gnt && bus.y_ready) r_state <= EMPTY;
            endcase
            if (w_gnt) begin
                r_data  <= w_gnt2 ? bus.data2 : bus.data1;
                r_owner <= w_gnt2;
                r_cnt   <= r_cnt + 1'b1;
                if (w_gnt2 == r_last) begin
                    r_burst <= (r_burst >= LP_MAX) ? LP_MAX : r_burst + 8'd1;
                end else begin
                    r_last  <= w_gnt2;
                    r_burst <= 8'd1;
                end
            end
        end
    end

    assign bus.gnt1     = w_gnt1;
    assign bus.gnt2     = w_gnt2;
    assign bus.y_data   = r_data;
    assign bus.y_valid  = (r_state == FULL);
    assign bus.y_owner  = r_owner;
    assign bus.xfer_cnt = r_cnt;
endmodule

// File: tb/tb_shared_stage_arb.sv
// Directed self-checking bench for shared_stage_arb (MAX_BURST=4, CW=4).
// Drives the interface, checks grants and the shared output register.
module tb_shared_stage_arb;
    localparam int WIDTH = 8;
    localparam int MB    = 4;
    localparam int CW    = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shared_stage_arb_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    shared_stage_arb #(
        .WIDTH(WIDTH),
        .MAX_BURST(MB),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] pat;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.y_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.y_valid), 0);
        chk("rst_data", 32'(bus.y_data), 0);
        chk("rst_owner", 32'(bus.y_owner), 0);
        chk("rst_cnt", 32'(bus.xfer_cnt), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_gnt2", 32'(bus.gnt2), 0);

        // Lone stream from requester 1
        bus.y_ready = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.data1 = 8'h11 + 8'(k);
            #1;
            chk("lone_gnt1", 32'(bus.gnt1), 1);
            chk("lone_gnt2", 32'(bus.gnt2), 0);
            tick();
            chk("lone_data", 32'(bus.y_data), 32'h11 + k);
            chk("lone_owner", 32'(bus.y_owner), 0);
            chk("lone_valid", 32'(bus.y_valid), 1);
        end
        bus.req1 = 1'b0;
        chk("lone_cnt", 32'(bus.xfer_cnt), 3);
        tick();
        chk("drain_valid", 32'(bus.y_valid), 0);

        // Contention after a fresh reset: 1,1,1,1,2,2,2,2,1,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pat = 10'b1100001111;
        bus.req1 = 1'b1;
        bus.req2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.data1 = 8'h20 + 8'(k);
            bus.data2 = 8'h40 + 8'(k);
            #1;
            chk("cont_gnt1", 32'(bus.gnt1), 32'(pat[k]));
            chk("cont_gnt2", 32'(bus.gnt2), 32'(!pat[k]));
            tick();
            chk("cont_owner", 32'(bus.y_owner), 32'(!pat[k]));
            chk("cont_data", 32'(bus.y_data),
                pat[k] ? 32'h20 + k : 32'h40 + k);
        end
        chk("cont_cnt", 32'(bus.xfer_cnt), 10);

        // Backpressure holding 0xA5
        bus.req1 = 1'b0;
        bus.req2 = 1'b1;
        bus.data2 = 8'hA5;
        tick();
        chk("bp_load", 32'(bus.y_data), 32'hA5);
        bus.y_ready = 1'b0;
        bus.data2 = 8'h77;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_gnt2", 32'(bus.gnt2), 0);
            chk("bp_gnt1", 32'(bus.gnt1), 0);
            tick();
            chk("bp_data", 32'(bus.y_data), 32'hA5);
            chk("bp_valid", 32'(bus.y_valid), 1);
            chk("bp_owner", 32'(bus.y_owner), 1);
        end
        bus.y_ready = 1'b1;
        #1;
        chk("bp_release_gnt2", 32'(bus.gnt2), 1);
        tick();
        chk("bp_new_data", 32'(bus.y_data), 32'h77);
        chk("bp_cnt", 32'(bus.xfer_cnt), 12);

        // Reset in the middle of backpressure
        bus.data2 = 8'h5A;
        tick();
        chk("mr_load", 32'(bus.y_data), 32'h5A);
        bus.req2 = 1'b0;
        bus.y_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 32'(bus.y_valid), 0);
        chk("mr_cnt", 32'(bus.xfer_cnt), 0);
        chk("mr_data", 32'(bus.y_data), 0);
        bus.req1 = 1'b1;
        bus.req2 = 1'b1;
        bus.data1 = 8'h31;
        bus.data2 = 8'h32;
        bus.y_ready = 1'b1;
        #1;
        chk("mr_gnt1", 32'(bus.gnt1), 1);
        chk("mr_gnt2", 32'(bus.gnt2), 0);
        tick();
        chk("mr_owner", 32'(bus.y_owner), 0);
        chk("mr_word", 32'(bus.y_data), 32'h31);

        // Counter wrap with CW=4: 17 lone transfers
        rst = 1'b1;
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
        tick();
        rst = 1'b0;
        bus.req2 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.data2 = 8'h80 + 8'(k);
            tick();
            chk("wrap_data", 32'(bus.y_data), 32'h80 + k);
            chk("wrap_owner", 32'(bus.y_owner), 1);
            if (k == 14) chk("wrap_cnt15", 32'(bus.xfer_cnt), 15);
            if (k == 15) chk("wrap_cnt0", 32'(bus.xfer_cnt), 0);
        end
        chk("wrap_cnt1", 32'(bus.xfer_cnt), 1);
        bus.req2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_stage_arb.md
Name: shared_stage_arb

Overview:
- Two-requester arbiter that shares one registered pass-through stage (a data register feeding a sink) between two sources.
- Each requester offers a word with req/data. The arbiter grants one per cycle and loads the winner's word into the shared output register. It holds that word until the downstream consumer accepts it.
- Fairness is round-robin with a bounded burst: the current holder keeps priority for at most MAX_BURST consecutive transfers while the other side is waiting.
- Sits between two producer submodules and the single shared sink register in the parent module.

Parameters:
- WIDTH, 8, data width of each requester and of the shared output.
- MAX_BURST, 4, max consecutive transfers by one requester while the other requests; legal range 1..255.
- CW, 16, width of the transfer counter xfer_cnt.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req1  in  1  requester 1 offers data1 this cycle.
- data1  in  WIDTH  requester 1 word.
- gnt1  out  1  requester 1 transfer accepted this cycle (combinational).
- req2  in  1  requester 2 offers data2 this cycle.
- data2  in  WIDTH  requester 2 word.
- gnt2  out  1  requester 2 transfer accepted this cycle (combinational).
- y_data  out  WIDTH  shared output register.
- y_valid  out  1  y_data holds an unconsumed word.
- y_ready  in  1  downstream accepts y_data when y_valid && y_ready.
- y_owner  out  1  source of y_data: 0 = requester 1, 1 = requester 2.
- xfer_cnt  out  CW  total accepted transfers since reset; wraps modulo 2^CW.

Behaviour:
- Reset (rst=1 at posedge):
  - y_valid=0, y_data=0, y_owner=0, xfer_cnt=0.
  - Internal last=1 (requester 2), burst=MAX_BURST.
  - Any word held in y_data is discarded.
  - gnt1/gnt2 remain combinational but no state is updated on that edge.
- FSM, 2 states:
  - EMPTY (y_valid=0).
  - FULL (y_valid=1).
  - EMPTY->FULL on any grant.
  - FULL->EMPTY on y_ready with no grant.
  - FULL->FULL on grant, or on !y_ready.
- slot_free = !y_valid || y_ready. A word is consumed and replaced in the same cycle when both occur.
- Selection sel:
  - Only req1: sel=0. Only req2: sel=1.
  - Both requesting: sel=last if burst<MAX_BURST, else sel=!last.
- Grants:
  - gnt1 = req1 && slot_free && sel==0.
  - gnt2 = req2 && slot_free && sel==1.
  - At most one grant is high per cycle.
  - No grant without req.
- On a grant from requester i (posedge):
  - y_data<=data_i, y_owner<=i, y_valid<=1.
  - xfer_cnt<=xfer_cnt+1.
  - If i==last: burst<=min(burst+1, MAX_BURST). Else: last<=i, burst<=1.
- Latency:
  - Word appears on y_data one cycle after its grant.
  - Throughput is one word per cycle when y_ready is held high.
- Backpressure: while y_valid && !y_ready, y_data, y_owner and y_valid are held stable and both grants are 0.
- Burst counter saturates at MAX_BURST. A lone requester streams indefinitely.
- With MAX_BURST=1, contended traffic strictly alternates.
- xfer_cnt wraps from 2^CW-1 to 0 without any flag.
- Reset asserted during backpressure or a burst:
  - Output slot clears next edge.
  - First contended grant after reset goes to requester 1.
- data_i is sampled only in the grant cycle. Data on non-granted cycles has no effect.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req=0 -> y_valid=0, y_data=0, y_owner=0, xfer_cnt=0, gnt1=gnt2=0.
- Lone stream: req1=1, data1=0x11,0x12,0x13 on consecutive cycles, y_ready=1 -> gnt1=1 every cycle; y_data=0x11,0x12,0x13 one cycle later with y_owner=0; xfer_cnt=3.
- Contention, MAX_BURST=4: req1=req2=1 continuously, y_ready=1 -> grant order 1,1,1,1,2,2,2,2,1...; first grant to requester 1 after reset.
- Backpressure: y_valid=1 with y_data=0xA5, y_ready=0 for 5 cycles, req2=1 -> gnt2=0 and y_data stays 0xA5 for all 5 cycles. Then y_ready=1 -> gnt2=1 in that same cycle; the new word appears the next cycle.
- Mid-operation reset: during backpressure (y_valid=1, y_data=0x5A, last=2), assert rst for 1 cycle -> y_valid=0, xfer_cnt=0. Next both-req cycle grants requester 1.
- Counter wrap, CW=4: 17 lone transfers -> xfer_cnt reads 1; y_data correct throughout.
